// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side ALU operand selection.
// Holds on stall, inserts a bubble on flush (flush wins), rewrites jal into ADD of PC+4 and 4.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          stall,
  input  logic          flush,
  input  logic          dwreg,
  input  logic          dm2reg,
  input  logic          dwmem,
  input  logic [3:0]    daluc,
  input  logic          daluimm,
  input  logic          dshift,
  input  logic          djal,
  input  logic [DW-1:0] dpc4,
  input  logic [DW-1:0] da,
  input  logic [DW-1:0] db,
  input  logic [DW-1:0] dimm,
  input  logic [RW-1:0] drn,
  output logic          evalid,
  output logic          ewreg,
  output logic          em2reg,
  output logic          ewmem,
  output logic [3:0]    ealuc,
  output logic [RW-1:0] ern,
  output logic [DW-1:0] eb,
  output logic [DW-1:0] alu_ina,
  output logic [DW-1:0] alu_inb
);

  logic [DW-1:0] epc4_r;
  logic [DW-1:0] ea_r;
  logic [DW-1:0] eimm_r;
  logic          eshift_r;
  logic          ealuimm_r;
  logic          ejal_r;

  // Stage register: flush loads a bubble, stall holds, otherwise capture decode outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      evalid    <= 1'b0;
      ewreg     <= 1'b0;
      em2reg    <= 1'b0;
      ewmem     <= 1'b0;
      ealuc     <= 4'b0000;
      ern       <= {RW{1'b0}};
      eb        <= {DW{1'b0}};
      epc4_r    <= {DW{1'b0}};
      ea_r      <= {DW{1'b0}};
      eimm_r    <= {DW{1'b0}};
      eshift_r  <= 1'b0;
      ealuimm_r <= 1'b0;
      ejal_r    <= 1'b0;
    end else if (flush) begin
      evalid    <= 1'b0;
      ewreg     <= 1'b0;
      em2reg    <= 1'b0;
      ewmem     <= 1'b0;
      ealuc     <= 4'b0000;
      ern       <= {RW{1'b0}};
      eb        <= {DW{1'b0}};
      epc4_r    <= {DW{1'b0}};
      ea_r      <= {DW{1'b0}};
      eimm_r    <= {DW{1'b0}};
      eshift_r  <= 1'b0;
      ealuimm_r <= 1'b0;
      ejal_r    <= 1'b0;
    end else if (!stall) begin
      // jal becomes "write PC+8 to r31": force ADD, link register and register write
      evalid    <= 1'b1;
      ewreg     <= djal ? 1'b1 : dwreg;
      em2reg    <= djal ? 1'b0 : dm2reg;
      ewmem     <= djal ? 1'b0 : dwmem;
      ealuc     <= djal ? 4'b0000 : daluc;
      ern       <= djal ? {RW{1'b1}} : drn;
      eb        <= db;
      epc4_r    <= dpc4;
      ea_r      <= da;
      eimm_r    <= dimm;
      eshift_r  <= dshift;
      ealuimm_r <= daluimm;
      ejal_r    <= djal;
    end
  end

  // ALU operand A: PC+4 for jal, shift amount for shifts, else rs
  always_comb begin
    alu_ina = ea_r;
    if (ejal_r) begin
      alu_ina = epc4_r;
    end else if (eshift_r) begin
      alu_ina = {{(DW-5){1'b0}}, eimm_r[10:6]};
    end else begin
      alu_ina = ea_r;
    end
  end

  // ALU operand B: constant 4 for jal, immediate when selected, else rt
  always_comb begin
    alu_inb = eb;
    if (ejal_r) begin
      alu_inb = {{(DW-3){1'b0}}, 3'b100};
    end else if (ealuimm_r) begin
      alu_inb = eimm_r;
    end else begin
      alu_inb = eb;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized run against a stage model.
module tb_id_ex_stage;

  logic        clock;
  logic        resetn;
  logic        stall, flush;
  logic        dwreg, dm2reg, dwmem, daluimm, dshift, djal;
  logic [3:0]  daluc;
  logic [31:0] dpc4, da, db, dimm;
  logic [4:0]  drn;
  logic        evalid, ewreg, em2reg, ewmem;
  logic [3:0]  ealuc;
  logic [4:0]  ern;
  logic [31:0] eb, alu_ina, alu_inb;

  int checks = 0;
  int errors = 0;

  // What the stage should hold, as seen from the instruction's point of view
  typedef struct {
    bit          valid, wreg, m2reg, wmem, aluimm, shift, jal;
    bit [3:0]    aluc;
    bit [4:0]    rn;
    bit [31:0]   pc4, a, b, imm;
  } stage_t;

  stage_t mdl;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clock(clock), .resetn(resetn), .stall(stall), .flush(flush),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluc(daluc),
    .daluimm(daluimm), .dshift(dshift), .djal(djal), .dpc4(dpc4),
    .da(da), .db(db), .dimm(dimm), .drn(drn),
    .evalid(evalid), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealuc(ealuc), .ern(ern), .eb(eb), .alu_ina(alu_ina), .alu_inb(alu_inb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic stage_t empty_stage();
    stage_t s;
    s = '{default: 0};
    return s;
  endfunction

  // jal computes PC+4 + 4 into r31; otherwise the instruction's own operands
  function automatic bit [31:0] exp_ina(stage_t s);
    if (s.jal) return s.pc4;
    if (s.shift) return 32'(s.imm[10:6]);
    return s.a;
  endfunction

  function automatic bit [31:0] exp_inb(stage_t s);
    if (s.jal) return 32'd4;
    if (s.aluimm) return s.imm;
    return s.b;
  endfunction

  task automatic clear_inputs();
    stall = 1'b0; flush = 1'b0;
    dwreg = 1'b0; dm2reg = 1'b0; dwmem = 1'b0; daluimm = 1'b0;
    dshift = 1'b0; djal = 1'b0; daluc = 4'd0; drn = 5'd0;
    dpc4 = 32'd0; da = 32'd0; db = 32'd0; dimm = 32'd0;
  endtask

  task automatic rand_inputs();
    dwreg = 1'($urandom); dm2reg = 1'($urandom); dwmem = 1'($urandom);
    daluimm = 1'($urandom); dshift = 1'($urandom);
    djal = ($urandom_range(0, 3) == 0);
    daluc = 4'($urandom); drn = 5'($urandom);
    dpc4 = $urandom; da = $urandom; db = $urandom; dimm = $urandom;
  endtask

  // One clock edge; model the instruction that the edge should leave in the stage
  task automatic step();
    stage_t nxt;
    if (!resetn || flush) begin
      nxt = empty_stage();
    end else if (stall) begin
      nxt = mdl;
    end else begin
      nxt.valid = 1; nxt.aluimm = daluimm; nxt.shift = dshift; nxt.jal = djal;
      nxt.pc4 = dpc4; nxt.a = da; nxt.b = db; nxt.imm = dimm;
      if (djal) begin
        nxt.wreg = 1; nxt.m2reg = 0; nxt.wmem = 0; nxt.aluc = 4'd0; nxt.rn = 5'd31;
      end else begin
        nxt.wreg = dwreg; nxt.m2reg = dm2reg; nxt.wmem = dwmem; nxt.aluc = daluc; nxt.rn = drn;
      end
    end
    @(posedge clock);
    #1;
    mdl = nxt;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    rand_inputs();
    mdl = empty_stage();
    #3;
    checks++;
    if ({evalid, ewreg, em2reg, ewmem, ealuc, ern, eb, alu_ina, alu_inb} !== 80'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b w=%b m=%b wm=%b aluc=%h rn=%0d eb=%h ina=%h inb=%h want all 0",
               evalid, ewreg, em2reg, ewmem, ealuc, ern, eb, alu_ina, alu_inb);
    end
    @(posedge clock); #1;
    checks++;
    if (evalid !== 1'b0) begin
      errors++; $display("FAIL reset_held_evalid got %b want 0", evalid);
    end
    clear_inputs();
    da = 32'd5; db = 32'd7;
    resetn = 1'b1;
    step();
    checks++;
    if (evalid !== 1'b1 || alu_ina !== 32'd5 || alu_inb !== 32'd7) begin
      errors++;
      $display("FAIL reset_release_load got v=%b ina=%0d inb=%0d want v=1 ina=5 inb=7", evalid, alu_ina, alu_inb);
    end
  endtask

  task automatic test_imm_shift();
    clear_inputs();
    daluimm = 1'b1; dimm = 32'h0000FFF0; db = 32'd3; da = 32'h55;
    step();
    checks++;
    if (alu_inb !== 32'h0000FFF0 || eb !== 32'd3 || alu_ina !== 32'h55) begin
      errors++;
      $display("FAIL imm_select got inb=%h eb=%h ina=%h want inb=0000fff0 eb=3 ina=55", alu_inb, eb, alu_ina);
    end
    clear_inputs();
    dshift = 1'b1; dimm = 32'hFFFF_F000 | (32'd4 << 6); db = 32'h10; daluc = 4'b0011; da = 32'h99;
    step();
    checks++;
    if (alu_ina !== 32'd4 || alu_inb !== 32'h10 || ealuc !== 4'b0011) begin
      errors++;
      $display("FAIL shift_select got ina=%h inb=%h aluc=%h want ina=4 inb=10 aluc=3", alu_ina, alu_inb, ealuc);
    end
  endtask

  task automatic test_jal();
    clear_inputs();
    djal = 1'b1; dpc4 = 32'h00400010; drn = 5'd0; daluc = 4'b0101;
    dm2reg = 1'b1; dwmem = 1'b1; daluimm = 1'b1; dshift = 1'b1; dimm = 32'h1234; da = 32'hDEAD;
    step();
    checks++;
    if (alu_ina !== 32'h00400010 || alu_inb !== 32'd4) begin
      errors++;
      $display("FAIL jal_operands got ina=%h inb=%h want ina=00400010 inb=4", alu_ina, alu_inb);
    end
    checks++;
    if (ealuc !== 4'b0000 || ern !== 5'd31 || ewreg !== 1'b1 || em2reg !== 1'b0 || ewmem !== 1'b0) begin
      errors++;
      $display("FAIL jal_control got aluc=%h rn=%0d w=%b m=%b wm=%b want aluc=0 rn=31 w=1 m=0 wm=0",
               ealuc, ern, ewreg, em2reg, ewmem);
    end
  endtask

  task automatic test_stall();
    clear_inputs();
    da = 32'hA;
    step();
    stall = 1'b1; da = 32'hB;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (alu_ina !== 32'hA || evalid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got ina=%h v=%b want ina=a v=1", i, alu_ina, evalid);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (alu_ina !== 32'hB) begin
      errors++; $display("FAIL stall_release got ina=%h want b", alu_ina);
    end
  endtask

  task automatic test_flush_stall();
    clear_inputs();
    dwreg = 1'b1; dwmem = 1'b1; daluc = 4'b0110; drn = 5'd9; db = 32'h77;
    step();
    stall = 1'b1; flush = 1'b1;
    step();
    checks++;
    if (evalid !== 1'b0 || ewreg !== 1'b0 || ewmem !== 1'b0 || ealuc !== 4'b0000 || ern !== 5'd0
        || eb !== 32'd0 || alu_ina !== 32'd0 || alu_inb !== 32'd0) begin
      errors++;
      $display("FAIL flush_over_stall got v=%b w=%b wm=%b aluc=%h rn=%0d eb=%h ina=%h inb=%h want all 0",
               evalid, ewreg, ewmem, ealuc, ern, eb, alu_ina, alu_inb);
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    clear_inputs();
    dwmem = 1'b1; da = 32'h3; drn = 5'd4;
    step();
    checks++;
    if (ewmem !== 1'b1) begin
      errors++; $display("FAIL async_pre_load got ewmem=%b want 1", ewmem);
    end
    #2 resetn = 1'b0;
    mdl = empty_stage();
    #1;
    checks++;
    if (ewmem !== 1'b0 || evalid !== 1'b0 || alu_ina !== 32'd0 || ern !== 5'd0) begin
      errors++;
      $display("FAIL async_reset_clear got wm=%b v=%b ina=%h rn=%0d want all 0", ewmem, evalid, alu_ina, ern);
    end
    #1 resetn = 1'b1;
    da = 32'h21;
    step();
    checks++;
    if (evalid !== 1'b1 || alu_ina !== 32'h21 || ewmem !== 1'b1) begin
      errors++;
      $display("FAIL async_release_load got v=%b ina=%h wm=%b want v=1 ina=21 wm=1", evalid, alu_ina, ewmem);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      step();
      checks++;
      if ({evalid, ewreg, em2reg, ewmem} !== {mdl.valid, mdl.wreg, mdl.m2reg, mdl.wmem}
          || ealuc !== mdl.aluc || ern !== mdl.rn) begin
        errors++;
        $display("FAIL rand_ctrl n=%0d got v=%b w=%b m=%b wm=%b aluc=%h rn=%0d want v=%b w=%b m=%b wm=%b aluc=%h rn=%0d",
                 n, evalid, ewreg, em2reg, ewmem, ealuc, ern,
                 mdl.valid, mdl.wreg, mdl.m2reg, mdl.wmem, mdl.aluc, mdl.rn);
      end
      checks++;
      if (eb !== mdl.b || alu_ina !== exp_ina(mdl) || alu_inb !== exp_inb(mdl)) begin
        errors++;
        $display("FAIL rand_data n=%0d got eb=%h ina=%h inb=%h want eb=%h ina=%h inb=%h",
                 n, eb, alu_ina, alu_inb, mdl.b, exp_ina(mdl), exp_inb(mdl));
      end
    end
  endtask

  initial begin
    test_reset();
    test_imm_shift();
    test_jal();
    test_stall();
    test_flush_stall();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand selection for the 5-stage MIPS pipeline.
- Captures decoded control, register operands, immediate, shift amount and PC+4 from decode.
- Drives the ALU's alu_ina, alu_inb and ealuc directly, and passes write-back/memory control downstream to EX/MEM.
- Handles load-use stalls and branch/jump flushes by holding or inserting a bubble.

Parameters:
- DW, 32, datapath width (operands, immediate, PC).
- RW, 5, register-number width.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- stall  in  1  hold all stage contents (hazard unit).
- flush  in  1  load a bubble instead of decode outputs.
- dwreg  in  1  decode: write register file.
- dm2reg  in  1  decode: result from memory.
- dwmem  in  1  decode: write memory.
- daluc  in  4  decode: ALU control code.
- daluimm  in  1  decode: ALU B operand is the immediate.
- dshift  in  1  decode: ALU A operand is the shift amount.
- djal  in  1  decode: jump-and-link.
- dpc4  in  DW  decode: PC+4.
- da  in  DW  decode: forwarded rs value.
- db  in  DW  decode: forwarded rt value.
- dimm  in  DW  decode: extended immediate (bits 10:6 hold sa).
- drn  in  RW  decode: destination register number.
- evalid  out  1  stage holds a real instruction.
- ewreg, em2reg, ewmem  out  1 each  registered control to EX/MEM.
- ealuc  out  4  ALU control to the ALU.
- ern  out  RW  destination register to EX/MEM.
- eb  out  DW  registered rt value (store data).
- alu_ina  out  DW  ALU operand A (combinational from registers).
- alu_inb  out  DW  ALU operand B (combinational from registers).

Behaviour:
- resetn low (asynchronous): every register clears to 0. Outputs evalid, ewreg, em2reg, ewmem, ealuc, ern, eb are all 0. alu_ina and alu_inb both read 0.
- Each rising edge with resetn high, priority is flush > stall > load:
  - flush: load a bubble. evalid, ewreg, em2reg, ewmem and ejal are 0. ealuc is 0000. All data registers and ern are 0.
  - stall (and no flush): every register holds its value.
  - otherwise: load all decode inputs; evalid becomes 1.
- jal load (djal=1, not flush, not stall):
  - ern is forced to 31.
  - ealuc is forced to 0000 (ADD).
  - ewreg is forced to 1.
  - em2reg and ewmem are forced to 0.
- Operand select, combinational from the E registers:
  - alu_ina = epc4 if ejal; else {27'b0, eimm[10:6]} if eshift; else ea.
  - alu_inb = 32'd4 if ejal; else eimm if ealuimm; else eb.
  - Net effect of jal: the ALU produces PC+8, the return address.
- eb always carries the registered db, independent of ealuimm, so stores keep their rt data.
- Latency: one cycle from decode inputs to E outputs. No combinational path from any d* input to any output.
- Simultaneous stall and flush: the bubble wins (used when a branch resolves during a load-use stall).
- Reset asserted mid-stall or mid-flush clears immediately. The first edge after release loads normally, unless stall or flush is asserted.

Test Plan:
- Reset: drive arbitrary d* values with resetn=0 -> all outputs 0. Release resetn with da=5, db=7, daluc=0000 -> next edge evalid=1, alu_ina=5, alu_inb=7.
- Immediate/shift: daluimm=1, dimm=0x0000FFF0, db=3 -> alu_inb=0x0000FFF0, eb=3. Next, dshift=1, dimm[10:6]=4, db=0x10, daluc=0011 -> alu_ina=4, alu_inb=0x10.
- jal: djal=1, dpc4=0x00400010, drn=0, daluc=0101 -> alu_ina=0x00400010, alu_inb=4, ealuc=0000, ern=31, ewreg=1.
- Stall: load da=0xA, then set stall=1 for 3 cycles while da=0xB -> alu_ina stays 0xA. Release -> 0xB appears one edge later.
- Flush vs stall: stall=1 and flush=1 with dwreg=1, dwmem=1 -> next edge evalid=0, ewreg=0, ewmem=0, ealuc=0000, ern=0.
- Async reset mid-operation: pulse resetn low between edges while ewmem=1 -> ewmem drops to 0 without a clock edge.
